// File: rtl/pipe_reg_skid_pkg.sv
// -----------------------------------------------------------------------------
// pipe_reg_pkg
// Shared types for the pipe_reg_skid pipeline register.
//   skid_state_t : occupancy-coded FSM state (EMPTY / ONE / TWO)
//   OCC_W        : width of the occupancy output
//   occ_of()     : maps an FSM state to its entry count
// -----------------------------------------------------------------------------
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int OCC_W = 2;

    // The state encoding equals the number of held entries. The function keeps
    // that mapping in one place.
    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
        logic [OCC_W-1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_reg_skid_data_reg.sv
// -----------------------------------------------------------------------------
// pipe_data_reg
// N-bit data register with a load enable and a synchronous active-low clear
// to RESET_VAL. The clear overrides the load.
// Ports:
//   i_clk    rising-edge clock
//   i_clr_n  synchronous active-low clear (loads RESET_VAL)
//   i_load   load i_d at the next edge
//   i_d      data in  [N-1:0]
//   o_q      data out [N-1:0]
// -----------------------------------------------------------------------------
module pipe_data_reg #(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_load,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// -----------------------------------------------------------------------------
// pipe_reg_skid
// N-bit pipeline register with a valid/ready handshake, 2-entry skid storage
// and a synchronous flush. The block sustains 1 word/cycle. in_ready comes
// straight from a flop, so downstream back-pressure never forms a
// combinational path to the upstream stage.
//
// Handshake: a word moves on an edge where valid && ready are both 1
// (accept = in_valid && in_ready, pop = out_valid && out_ready). A producer
// holds its data and valid until the transfer. in_valid is ignored while
// in_ready = 0.
//
// Optional feature: define PIPE_REG_SKID_PERF_EN to add the stall_cnt [CW-1:0]
// output. The counter saturates, counts cycles where out_valid && !out_ready,
// and is cleared only by CLR.
//
// Ports:
//   clk        rising-edge clock
//   CLR        synchronous active-low reset
//   flush      synchronous flush; discards all held entries
//   in_valid   upstream presents DataIn
//   in_ready   block can accept (registered)
//   DataIn     write data [N-1:0]
//   out_valid  DataOut holds a valid entry
//   out_ready  downstream accepts
//   DataOut    head entry data [N-1:0]
//   occupancy  entries held (0..2)
//   stall_cnt  stall cycle counter [CW-1:0] (PIPE_REG_SKID_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_reg_skid
    import pipe_reg_pkg::*;
#(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_VAL = '0
`ifdef PIPE_REG_SKID_PERF_EN
    ,
    parameter int           CW        = 16
`endif
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     DataIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     DataOut,
    output logic [OCC_W-1:0] occupancy
`ifdef PIPE_REG_SKID_PERF_EN
    ,
    output logic [CW-1:0]    stall_cnt
`endif
);

    skid_state_t  r_state;
    skid_state_t  w_next;
    logic         r_in_ready;

    logic         w_accept;
    logic         w_pop;
    logic         w_main_load;
    logic         w_main_from_skid;
    logic         w_skid_load;
    logic [N-1:0] w_main_d;
    logic [N-1:0] w_main_q;
    logic [N-1:0] w_skid_q;

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = out_valid && out_ready;

    // ---------------------------------------------------------------------
    // Next-state and data-register load selection
    // ---------------------------------------------------------------------
    always_comb begin
        w_next           = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;

        if (flush) begin
            // The data registers keep their contents. Only the state empties.
            // An accept in the same cycle is dropped. A pop in this cycle
            // still completes, because DataOut was valid.
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_next      = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_next      = TWO;
                    end else if (w_pop) begin
                        w_next = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_next           = ONE;
                    end
                end
                default: begin
                    w_next = EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : DataIn;

    // ---------------------------------------------------------------------
    // State register. in_ready is computed from the next state, so it is
    // available as a flop output in the following cycle.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!CLR) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != TWO);
        end
    end

    // ---------------------------------------------------------------------
    // Data storage
    // ---------------------------------------------------------------------
    pipe_data_reg #(
        .N         (N),
        .RESET_VAL (RESET_VAL)
    ) u_main_q (
        .i_clk   (clk),
        .i_clr_n (CLR),
        .i_load  (w_main_load),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    pipe_data_reg #(
        .N         (N),
        .RESET_VAL (RESET_VAL)
    ) u_skid_q (
        .i_clk   (clk),
        .i_clr_n (CLR),
        .i_load  (w_skid_load),
        .i_d     (DataIn),
        .o_q     (w_skid_q)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign DataOut   = w_main_q;
    assign occupancy = occ_of(r_state);

`ifdef PIPE_REG_SKID_PERF_EN
    // ---------------------------------------------------------------------
    // Stall counter. A flush does not clear it.
    // ---------------------------------------------------------------------
    logic [CW-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!CLR) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_skid
// Self-checking bench for pipe_reg_skid. The reference is a bounded FIFO
// (exp_q, capacity 2) plus the last head value shown on DataOut. Directed
// scenarios come first. A randomized run with occasional flush and reset
// follows.
// -----------------------------------------------------------------------------
module tb_pipe_reg_skid;

  localparam int          W     = 32;
  localparam logic [W-1:0] R_VAL = 32'hA5A5_0F0F;
  localparam int          CW_TB = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         CLR;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] DataIn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] DataOut;
  logic [1:0]   occupancy;
`ifdef PIPE_REG_SKID_PERF_EN
  logic [CW_TB-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_reg_skid #(
    .N         (W),
    .RESET_VAL (R_VAL)
`ifdef PIPE_REG_SKID_PERF_EN
    ,
    .CW        (CW_TB)
`endif
  ) dut (
    .clk       (clk),
    .CLR       (CLR),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .DataIn    (DataIn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DataOut   (DataOut),
    .occupancy (occupancy)
`ifdef PIPE_REG_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
  int           stall_raw;
  logic         last_acc;
  int           n_checks;
  int           n_errors;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock. The model is updated from the inputs seen at the edge.
  // Outputs are compared at the following negedge.
  task automatic tick();
    logic acc;
    logic pop;
    int   exp_stall;
    acc = in_valid && (exp_q.size() < 2);
    pop = (exp_q.size() > 0) && out_ready;
    @(posedge clk);
    if (!CLR) begin
      exp_q.delete();
      exp_dout  = R_VAL;
      stall_raw = 0;
      last_acc  = 1'b0;
    end else begin
      if ((exp_q.size() > 0) && !out_ready) stall_raw++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(DataIn);
      end
      if (exp_q.size() > 0) exp_dout = exp_q[0];
      last_acc = acc;
    end
    @(negedge clk);
    check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
    check("in_ready",  W'(in_ready),  W'(exp_q.size() < 2));
    check("occupancy", W'(occupancy), W'(exp_q.size()));
    check("DataOut",   DataOut,       exp_dout);
    exp_stall = (stall_raw > (2**CW_TB - 1)) ? (2**CW_TB - 1) : stall_raw;
`ifdef PIPE_REG_SKID_PERF_EN
    check("stall_cnt", W'(stall_cnt), W'(exp_stall));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W-1:0] w);
    in_valid = 1'b1;
    DataIn   = w;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    check("push_accept", W'(last_acc), W'(1));
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    stall_raw = 0;
    last_acc  = 1'b0;
    exp_dout  = R_VAL;
    CLR       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    DataIn    = 32'h1234_5678;

    // Reset: two edges with in_valid asserted.
    tick();
    tick();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_occ",       W'(occupancy), W'(0));
    check("rst_dout",      DataOut,       R_VAL);
    CLR      = 1'b1;
    in_valid = 1'b0;
    tick();

    // Streaming: back-to-back words with out_ready high.
    out_ready = 1'b1;
    push(32'hAB);
    check("stream_ab", DataOut, 32'hAB);
    push(32'hCD);
    check("stream_cd", DataOut, 32'hCD);
    check("stream_occ", W'(occupancy), W'(1));
    push(32'hEF);
    check("stream_ef", DataOut, 32'hEF);
    check("stream_rdy", W'(in_ready), W'(1));
    tick();
    check("stream_drain", W'(out_valid), W'(0));

    // Back-pressure: fill both entries, third word is held off.
    out_ready = 1'b0;
    push(32'h11);
    push(32'h22);
    in_valid = 1'b1;
    DataIn   = 32'h33;
    tick();
    check("bp_not_acc", W'(last_acc),  W'(0));
    check("bp_occ",     W'(occupancy), W'(2));
    check("bp_rdy",     W'(in_ready),  W'(0));
    check("bp_head",    DataOut,       32'h11);
    out_ready = 1'b1;
    tick();
    check("bp_pop11", DataOut, 32'h22);
    check("bp_33_wait", W'(last_acc), W'(0));
    tick();
    check("bp_33_acc", W'(last_acc), W'(1));
    check("bp_pop22", DataOut, 32'h33);
    in_valid = 1'b0;
    tick();
    check("bp_empty", W'(out_valid), W'(0));

    // Flush in TWO while an accept is attempted.
    out_ready = 1'b0;
    push(32'h60);
    push(32'h61);
    in_valid = 1'b1;
    DataIn   = 32'h99;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_occ",   W'(occupancy), W'(0));
    check("fl_valid", W'(out_valid), W'(0));
    out_ready = 1'b1;
    push(32'h55);
    check("fl_head55", DataOut, 32'h55);
    tick();
    check("fl_only55", W'(out_valid), W'(0));

    // Reset while holding two entries.
    out_ready = 1'b0;
    push(32'h77);
    push(32'h88);
    do_reset();
    check("clr_dout", DataOut,       R_VAL);
    check("clr_occ",  W'(occupancy), W'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_no_stale", W'(out_valid), W'(0));
    end

    // Randomized run against the model.
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        DataIn   = $urandom;
      end
      out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      CLR       = ($urandom_range(0, 79) != 0);
      tick();
    end
    CLR      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;

`ifdef PIPE_REG_SKID_PERF_EN
    // Stall counter: saturation, survives flush, cleared by reset.
    do_reset();
    out_ready = 1'b0;
    push(32'h42);
    for (int i = 0; i < 20; i++) tick();
    check("perf_sat", W'(stall_cnt), W'(15));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_flush", W'(stall_cnt), W'(15));
    do_reset();
    check("perf_clr", W'(stall_cnt), W'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
